// File: rtl/store_modifier_pkg.sv
// Shared store/load lane conventions.
// Size codes, base strobe masks and store FSM states.
package store_modifier_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } state_e;

  function automatic logic [3:0] base_mask(size_e sz);
    logic [3:0] r;
    r = MASK_WORD;
    unique case (sz)
      SZ_BYTE: r = MASK_BYTE;
      SZ_HALF: r = MASK_HALF;
      default: r = MASK_WORD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/store_modifier_if.sv
// Store request and data-memory write bus.
// slave = store unit view, master = requester/memory view.
interface store_modifier_if #(
  parameter int ADDR_W = 32
);
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_sb;
  logic              i_sh;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_wdata;
  logic              o_mem_valid;
  logic              i_mem_ready;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic [3:0]        o_mem_wstrb;
  logic              o_done;
  logic              o_misaligned;

  modport slave (
    input  i_req_valid, i_sb, i_sh,
    input  i_addr, i_wdata, i_mem_ready,
    output o_req_ready, o_mem_valid,
    output o_mem_addr, o_mem_wdata,
    output o_mem_wstrb, o_done,
    output o_misaligned
  );

  modport master (
    output i_req_valid, i_sb, i_sh,
    output i_addr, i_wdata, i_mem_ready,
    input  o_req_ready, o_mem_valid,
    input  o_mem_addr, o_mem_wdata,
    input  o_mem_wstrb, o_done,
    input  o_misaligned
  );
endinterface

// File: rtl/store_lane_align.sv
// Rotates store data into byte lanes and builds the
// two-word strobe window for a given size and offset.
module store_lane_align
  import store_modifier_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [31:0] rot,
  output logic [7:0]  m,
  output logic        need_beat1
);

  always_comb begin
    rot = wdata;
    unique case (off)
      2'd0: rot = wdata;
      2'd1: rot = {wdata[23:0], wdata[31:24]};
      2'd2: rot = {wdata[15:0], wdata[31:16]};
      2'd3: rot = {wdata[7:0],  wdata[31:8]};
      default: rot = wdata;
    endcase
  end

  // Upper nibble is the spill into the next word.
  assign m = {4'b0000, base_mask(size)} << off;
  assign need_beat1 = |m[7:4];

endmodule

// File: rtl/store_modifier.sv
// MEM-stage store unit: lane alignment, strobes and
// optional two-beat split of word-crossing stores.
module store_modifier
  import store_modifier_pkg::*;
#(
  parameter bit SPLIT_MISALIGNED = 1'b1,
  parameter int ADDR_W           = 32
) (
  input logic            i_clk,
  input logic            i_resetn,
  store_modifier_if.slave bus
);

  state_e      state;
  size_e       size;
  logic [31:0] rot;
  logic [7:0]  m;
  logic        need_beat1;
  logic [3:0]  hi_strb;

  always_comb begin
    size = SZ_WORD;
    priority case (1'b1)
      bus.i_sb: size = SZ_BYTE;
      bus.i_sh: size = SZ_HALF;
      default:  size = SZ_WORD;
    endcase
  end

  store_lane_align u_align (
    .size       (size),
    .off        (bus.i_addr[1:0]),
    .wdata      (bus.i_wdata),
    .rot        (rot),
    .m          (m),
    .need_beat1 (need_beat1)
  );

  assign bus.o_req_ready = (state == ST_IDLE);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state            <= ST_IDLE;
      bus.o_mem_valid  <= 1'b0;
      bus.o_mem_addr   <= '0;
      bus.o_mem_wdata  <= '0;
      bus.o_mem_wstrb  <= '0;
      bus.o_done       <= 1'b0;
      bus.o_misaligned <= 1'b0;
      hi_strb          <= '0;
    end else begin
      bus.o_done       <= 1'b0;
      bus.o_misaligned <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.i_req_valid) begin
            if (need_beat1 && !SPLIT_MISALIGNED) begin
              bus.o_misaligned <= 1'b1;
            end else begin
              state           <= ST_BEAT0;
              bus.o_mem_valid <= 1'b1;
              bus.o_mem_addr  <= {bus.i_addr[ADDR_W-1:2], 2'b00};
              bus.o_mem_wdata <= rot;
              bus.o_mem_wstrb <= m[3:0];
              hi_strb         <= m[7:4];
            end
          end
        end
        ST_BEAT0: begin
          if (bus.i_mem_ready) begin
            if (|hi_strb) begin
              state           <= ST_BEAT1;
              bus.o_mem_addr  <= bus.o_mem_addr + ADDR_W'(4);
              bus.o_mem_wstrb <= hi_strb;
            end else begin
              state           <= ST_IDLE;
              bus.o_mem_valid <= 1'b0;
              bus.o_done      <= 1'b1;
            end
          end
        end
        ST_BEAT1: begin
          if (bus.i_mem_ready) begin
            state           <= ST_IDLE;
            bus.o_mem_valid <= 1'b0;
            bus.o_done      <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_modifier.sv
// Directed bench for store_modifier (split and drop
// variants side by side on one clock).
module tb_store_modifier;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  store_modifier_if #(.ADDR_W(32)) a ();
  store_modifier_if #(.ADDR_W(32)) b ();

  store_modifier #(.SPLIT_MISALIGNED(1'b1), .ADDR_W(32)) dut_a (
    .i_clk    (clk),
    .i_resetn (resetn),
    .bus      (a)
  );

  store_modifier #(.SPLIT_MISALIGNED(1'b0), .ADDR_W(32)) dut_b (
    .i_clk    (clk),
    .i_resetn (resetn),
    .bus      (b)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_a(input string tag,
                        input logic [31:0] addr,
                        input logic [31:0] data,
                        input logic [3:0]  strb);
    chk({tag, "_valid"}, 64'(a.o_mem_valid), 64'd1);
    chk({tag, "_addr"},  64'(a.o_mem_addr),  64'(addr));
    chk({tag, "_wdata"}, 64'(a.o_mem_wdata), 64'(data));
    chk({tag, "_wstrb"}, 64'(a.o_mem_wstrb), 64'(strb));
    chk({tag, "_done"},  64'(a.o_done),      64'd0);
    chk({tag, "_rdy"},   64'(a.o_req_ready), 64'd0);
  endtask

  task automatic done_a(input string tag);
    chk({tag, "_done"},  64'(a.o_done),      64'd1);
    chk({tag, "_valid"}, 64'(a.o_mem_valid), 64'd0);
    chk({tag, "_rdy"},   64'(a.o_req_ready), 64'd1);
  endtask

  // Presents a request for one cycle, leaves time at edge+1.
  task automatic issue(input bit to_b, input bit sb, input bit sh,
                       input logic [31:0] addr, input logic [31:0] data);
    if (to_b) begin
      b.i_req_valid = 1'b1; b.i_sb = sb; b.i_sh = sh;
      b.i_addr = addr; b.i_wdata = data;
    end else begin
      a.i_req_valid = 1'b1; a.i_sb = sb; a.i_sh = sh;
      a.i_addr = addr; a.i_wdata = data;
    end
    step();
    a.i_req_valid = 1'b0;
    b.i_req_valid = 1'b0;
  endtask

  initial begin
    a.i_req_valid = 0; a.i_sb = 0; a.i_sh = 0;
    a.i_addr = '0; a.i_wdata = '0; a.i_mem_ready = 1;
    b.i_req_valid = 0; b.i_sb = 0; b.i_sh = 0;
    b.i_addr = '0; b.i_wdata = '0; b.i_mem_ready = 1;

    #2;
    chk("rst_valid", 64'(a.o_mem_valid), 64'd0);
    chk("rst_addr",  64'(a.o_mem_addr),  64'd0);
    chk("rst_wdata", 64'(a.o_mem_wdata), 64'd0);
    chk("rst_wstrb", 64'(a.o_mem_wstrb), 64'd0);
    chk("rst_done",  64'(a.o_done),      64'd0);
    chk("rst_mis",   64'(b.o_misaligned), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    chk("rst_rdy", 64'(a.o_req_ready), 64'd1);

    // sw aligned
    issue(0, 0, 0, 32'h100, 32'hDEADBEEF);
    beat_a("sw100", 32'h100, 32'hDEADBEEF, 4'b1111);
    step();
    done_a("sw100_end");

    // sb at off 3, issued in the done cycle
    issue(0, 1, 0, 32'h203, 32'h000000A5);
    beat_a("sb203", 32'h200, 32'hA5000000, 4'b1000);
    step();
    done_a("sb203_end");

    // sb and sh both set: byte wins
    issue(0, 1, 1, 32'h401, 32'h00005577);
    beat_a("sbsh401", 32'h400, 32'h00557700, 4'b0010);
    step();
    done_a("sbsh401_end");
    step();
    chk("pulse_once", 64'(a.o_done), 64'd0);

    // sh crossing, split
    issue(0, 0, 1, 32'h303, 32'h00001234);
    beat_a("sh303_b0", 32'h300, 32'h34000012, 4'b1000);
    step();
    beat_a("sh303_b1", 32'h304, 32'h34000012, 4'b0001);
    step();
    done_a("sh303_end");
    step();

    // sw crossing the top of memory with stalls
    a.i_mem_ready = 1'b0;
    issue(0, 0, 0, 32'hFFFFFFFD, 32'h11223344);
    for (int i = 0; i < 3; i++) begin
      beat_a("wrap_b0", 32'hFFFFFFFC, 32'h22334411, 4'b1110);
      a.i_req_valid = 1'b1; a.i_addr = 32'h500;
      step();
      a.i_req_valid = 1'b0;
    end
    beat_a("wrap_b0h", 32'hFFFFFFFC, 32'h22334411, 4'b1110);
    a.i_mem_ready = 1'b1;
    step();
    a.i_mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat_a("wrap_b1", 32'h0, 32'h22334411, 4'b0001);
      step();
    end
    a.i_mem_ready = 1'b1;
    step();
    done_a("wrap_end");
    step();

    // drop variant: crossing sh is flagged, no beat
    issue(1, 0, 1, 32'h43, 32'h0000BEEF);
    chk("mis_pulse", 64'(b.o_misaligned), 64'd1);
    chk("mis_valid", 64'(b.o_mem_valid),  64'd0);
    chk("mis_done",  64'(b.o_done),       64'd0);
    chk("mis_rdy",   64'(b.o_req_ready),  64'd1);
    issue(1, 0, 1, 32'h42, 32'h0000BEEF);
    chk("mis_clr",   64'(b.o_misaligned), 64'd0);
    chk("b42_valid", 64'(b.o_mem_valid),  64'd1);
    chk("b42_addr",  64'(b.o_mem_addr),   64'h40);
    chk("b42_wdata", 64'(b.o_mem_wdata),  64'hBEEF0000);
    chk("b42_wstrb", 64'(b.o_mem_wstrb),  64'hC);
    step();
    chk("b42_done",  64'(b.o_done),       64'd1);
    chk("b42_idle",  64'(b.o_mem_valid),  64'd0);
    step();

    // reset during second beat
    issue(0, 0, 0, 32'h1, 32'h01020304);
    beat_a("rst_b0", 32'h0, 32'h02030401, 4'b1110);
    step();
    beat_a("rst_b1", 32'h4, 32'h02030401, 4'b0001);
    resetn = 1'b0;
    #1;
    chk("mid_valid", 64'(a.o_mem_valid), 64'd0);
    chk("mid_addr",  64'(a.o_mem_addr),  64'd0);
    chk("mid_wdata", 64'(a.o_mem_wdata), 64'd0);
    chk("mid_wstrb", 64'(a.o_mem_wstrb), 64'd0);
    chk("mid_done",  64'(a.o_done),      64'd0);
    step();
    chk("mid_nodone", 64'(a.o_done), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    chk("post_rdy", 64'(a.o_req_ready), 64'd1);
    chk("post_nodone", 64'(a.o_done), 64'd0);
    issue(0, 0, 0, 32'h0, 32'hCAFEF00D);
    beat_a("post_sw", 32'h0, 32'hCAFEF00D, 4'b1111);
    step();
    done_a("post_sw_end");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/store_modifier.md
Name: store_modifier

Overview:
- Store-side counterpart of the load path: takes sb/sh/sw requests from the MEM stage and drives byte-lane-aligned write data plus byte strobes to the 32-bit data-memory port.
- Word-aligned memory interface with a valid/ready handshake.
- Misaligned halfword/word stores are split into two word beats. Alternatively, they are flagged and dropped, depending on a parameter.
- Holds the pipeline through o_req_ready until the store completes.

Parameters:
SPLIT_MISALIGNED, 1, 1 = split word-crossing stores into two beats; 0 = pulse o_misaligned and issue no memory access
ADDR_W, 32, address width (byte address)

Ports:
i_clk  input  1  clock
i_resetn  input  1  asynchronous active-low reset
i_req_valid  input  1  store request valid
o_req_ready  output  1  block idle, can accept a request
i_sb  input  1  store byte
i_sh  input  1  store halfword (i_sb=i_sh=0 means sw)
i_addr  input  ADDR_W  byte address
i_wdata  input  32  rs2 data, right-justified
o_mem_valid  output  1  memory write beat valid
i_mem_ready  input  1  memory accepts beat
o_mem_addr  output  ADDR_W  word-aligned beat address ([1:0]=0)
o_mem_wdata  output  32  lane-aligned write data
o_mem_wstrb  output  4  byte enables, bit k = byte lane k
o_done  output  1  one-cycle pulse: store fully written
o_misaligned  output  1  one-cycle pulse: misaligned store dropped (SPLIT_MISALIGNED=0 only)

Behaviour:
- Reset: i_resetn is asynchronous and active-low; i_clk is the clock. All state is cleared on reset.
  - State = IDLE.
  - o_mem_valid=0, o_mem_addr=0, o_mem_wdata=0, o_mem_wstrb=0, o_done=0, o_misaligned=0.
  - o_req_ready=1 once reset is released.
  - A reset mid-transfer abandons the outstanding beat(s) without completion.
- Size decode:
  - i_sb=1 → byte; i_sb has priority when both i_sb and i_sh are set.
  - i_sh=1 → half.
  - Otherwise → word.
  - Base mask: byte=0001, half=0011, word=1111.
- Offset: off = i_addr[1:0].
  - 8-bit mask m = base << off.
  - Beat0 strobe = m[3:0]; beat1 strobe = m[7:4].
  - A second beat is needed iff m[7:4] != 0.
- Data: rot = i_wdata rotated left by 8*off. The same rot drives o_mem_wdata for both beats; only the strobe differs.
- Handshake:
  - Accept occurs when i_req_valid && o_req_ready.
  - o_req_ready is 1 only in IDLE.
- FSM states: IDLE, BEAT0, BEAT1.
  - IDLE --accept, aligned or split permitted--> BEAT0.
    - Registers are loaded: o_mem_addr = {i_addr[ADDR_W-1:2], 2'b00}, o_mem_wdata = rot, o_mem_wstrb = m[3:0].
    - o_mem_valid=1 from the next cycle (latency 1).
  - IDLE --accept, crossing, SPLIT_MISALIGNED=0--> stays IDLE.
    - o_misaligned pulses the next cycle.
    - No memory beat; o_done is not asserted.
  - BEAT0 --i_mem_ready, no second beat--> IDLE.
    - o_mem_valid=0 and o_done=1 on the next cycle.
  - BEAT0 --i_mem_ready, second beat--> BEAT1.
    - o_mem_addr += 4, with modulo-2^ADDR_W wrap (0xFFFFFFFC → 0x00000000).
    - o_mem_wstrb = m[7:4]; o_mem_valid stays 1.
  - BEAT1 --i_mem_ready--> IDLE, with o_done pulsed on the next cycle.
- While o_mem_valid=1 and i_mem_ready=0:
  - addr, wdata and wstrb are held stable.
  - o_mem_valid is not withdrawn.
- o_done and o_req_ready rise in the same cycle. A new request may be accepted in that cycle.
- i_req_valid while o_req_ready=0 is ignored. The requester holds the request.
- Byte stores never cross a word boundary. Half stores cross only at off=3. Word stores cross at off≠0.
- Minimum store time with i_mem_ready tied high:
  - Single beat: accept to o_done = 2 cycles.
  - Split store: 3 cycles.

Decomposition:
- Shared package:
  - Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD).
  - Base strobe masks.
  - FSM state enum.
  - These are shared with the load path for consistent lane conventions.
- One natural sub-module, store_lane_align (combinational):
  - Inputs: size, off, wdata.
  - Outputs: rot, m[7:0], need_beat1.
  - The FSM/register wrapper stays in store_modifier.

Test Plan:
- sw addr=0x100, wdata=0xDEADBEEF, mem_ready=1 → one beat: addr 0x100, wdata 0xDEADBEEF, wstrb 1111; o_done 2 cycles after accept.
- sb addr=0x203, wdata=0x000000A5 → addr 0x200, wdata 0xA5xxxxxx in lane3 (rot 0xA5000000), wstrb 1000; single beat.
- sh addr=0x303, wdata=0x00001234, SPLIT=1 → beat0 addr 0x300 wstrb 1000 lane3=0x34; beat1 addr 0x304 wstrb 0001 lane0=0x12; o_done once.
- sw addr=0xFFFFFFFD, wdata=0x11223344, mem_ready low 3 cycles per beat → beat0 addr 0xFFFFFFFC wstrb 1110 held stable while stalled; beat1 addr 0x00000000 wstrb 0001, lane0=0x11.
- SPLIT_MISALIGNED=0, sh addr=0x43 → o_misaligned pulse, o_mem_valid never asserted, o_req_ready back next cycle; then sh addr=0x42 data 0xBEEF → wstrb 1100, wdata 0xBEEFxxxx.
- Reset asserted during BEAT1 of a split sw → all outputs 0 immediately, no o_done; a fresh sw at 0x0 after release completes normally.
